// File: rtl/accu_avg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : accu_avg_fifo
// Brief    : Captures accumulator sum pulses into a small FIFO and presents the
//            averaged result (sum >> SHIFT) over a ready/valid interface.
//            When the FIFO is full, an incoming sum is dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module accu_avg_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int SHIFT  = 2,
  parameter int OUT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [OUT_W-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;

  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full FIFO still accepts a push when a pop frees the head this cycle.
  assign w_pop  = (level_q != '0) && ready_in;
  assign w_push = valid_in && ((level_q < FULL_LVL) || w_pop);
  assign w_drop = valid_in && !w_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (w_push && !w_pop)      level_d = level_q + 1'b1;
    else if (w_pop && !w_push) level_d = level_q - 1'b1;

    // A drop in the same cycle as a clear wins, restarting the count at 1.
    if (w_drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)              drop_d = 8'd1;
      else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_in;
  end

  assign valid_out = (level_q != '0);
  assign data_out  = mem_q[rd_ptr_q][DATA_W-1:SHIFT];
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_accu_avg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_accu_avg_fifo
// Brief    : Directed and randomized bench for accu_avg_fifo with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accu_avg_fifo;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [9:0] data_in;
  logic       ready_in;
  logic       valid_out;
  logic [7:0] data_out;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  int q[$];
  bit m_ovf;
  int m_cnt;

  accu_avg_fifo #(.DATA_W(10), .DEPTH(DEPTH), .SHIFT(2), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'(q.size() != 0));
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, ".cnt"},   32'(drop_cnt), 32'(m_cnt));
    if (q.size() != 0) chk({tag, ".data"}, 32'(data_out), 32'(q[0] / 4));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input string tag, input logic v, input int d,
                      input logic r, input logic c);
    bit pop, acc;
    valid_in = v;
    data_in  = 10'(d);
    ready_in = r;
    clr_ovf  = c;
    @(posedge clk);
    pop = (q.size() != 0) && r;
    acc = v && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (v && !acc) begin
      m_ovf = 1'b1;
      if (c) m_cnt = 1;
      else if (m_cnt < 255) m_cnt++;
    end else if (c) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0; clr_ovf = 1'b0;
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("post_reset");

    // Single push, visible after the edge, then a single pop.
    step("push400", 1'b1, 400, 1'b0, 1'b0);
    chk("push400.data100", 32'(data_out), 32'd100);
    step("pop400", 1'b0, 0, 1'b1, 1'b0);

    // Burst of four, then drain.
    step("b0", 1'b1, 4,    1'b0, 1'b0);
    step("b1", 1'b1, 8,    1'b0, 1'b0);
    step("b2", 1'b1, 1020, 1'b0, 1'b0);
    step("b3", 1'b1, 13,   1'b0, 1'b0);
    chk("burst.full", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 0, 1'b1, 1'b0);

    // Fill, drop two while stalled, then clear.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 100 + i, 1'b0, 1'b0);
    step("drop1", 1'b1, 900, 1'b0, 1'b0);
    step("drop2", 1'b1, 901, 1'b0, 1'b0);
    chk("drop.cnt2", 32'(drop_cnt), 32'd2);
    chk("drop.head", 32'(data_out), 32'd25);
    step("clr", 1'b0, 0, 1'b0, 1'b1);

    // Full with simultaneous pop and push: accepted.
    step("fullpp", 1'b1, 200, 1'b1, 1'b0);
    chk("fullpp.level", 32'(level), 32'd4);
    for (int i = 0; i < 3; i++) step("drain2", 1'b0, 0, 1'b1, 1'b0);
    chk("fullpp.last50", 32'(data_out), 32'd50);
    step("drain2", 1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with level 3.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 60 + i, 1'b0, 1'b0);
    valid_in = 1'b0; ready_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("async_rst_rel");
    step("push44", 1'b1, 44, 1'b0, 1'b0);
    chk("push44.data11", 32'(data_out), 32'd11);
    step("pop44", 1'b0, 0, 1'b1, 1'b0);

    // Saturation of the drop counter, then drop-and-clear together.
    for (int i = 0; i < 4; i++) step("sfill", 1'b1, 4 * i, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 7, 1'b0, 1'b0);
    chk("sat.255", 32'(drop_cnt), 32'd255);
    step("dropclr", 1'b1, 9, 1'b0, 1'b1);
    chk("dropclr.cnt1", 32'(drop_cnt), 32'd1);
    chk("dropclr.ovf1", 32'(overflow), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 1020)),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
